// File: rtl/alu_pkg.sv
// Shared opcode encoding and data width for the ALU and its shifter.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int SHAMT_W = 4;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter for SLL/SRL, including the last bit shifted out.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] amount,
  input  logic               right,
  output logic [DATA_W-1:0]  result,
  output logic               carry
);

  logic [DATA_W:0] left_ext;
  logic [DATA_W:0] right_ext;

  // Widen by one bit so the final shifted-out bit lands in the extension;
  // a zero shift leaves the extension bit 0, giving carry 0 for free.
  always_comb begin
    left_ext  = {1'b0, data} << amount;
    right_ext = {data, 1'b0} >> amount;
    if (right) begin
      result = right_ext[DATA_W:1];
      carry  = right_ext[0];
    end else begin
      result = left_ext[DATA_W-1:0];
      carry  = left_ext[DATA_W];
    end
  end

endmodule

// File: rtl/alu.sv
// 16-bit ALU: combinational result and flags, plus registered copies.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] Alu_inputA,
  input  logic [DATA_W-1:0] Alu_inputB,
  input  logic [2:0]        Alu_control,
  output logic [DATA_W-1:0] Alu_result,
  output logic              Zero,
  output logic              Carry,
  output logic              Overflow,
  output logic [DATA_W-1:0] Alu_result_q,
  output logic              Zero_q,
  output logic              Carry_q,
  output logic              Overflow_q
);

  alu_op_e           op;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] shift_result;
  logic              shift_carry;
  logic              sign_a;
  logic              sign_b;

  assign op     = alu_op_e'(Alu_control);
  assign sign_a = Alu_inputA[DATA_W-1];
  assign sign_b = Alu_inputB[DATA_W-1];

  // Only B[3:0] reaches the shifter, so upper B bits cannot affect shifts.
  alu_shifter u_shifter (
    .data   (Alu_inputA),
    .amount (Alu_inputB[SHAMT_W-1:0]),
    .right  (op == ALU_SRL),
    .result (shift_result),
    .carry  (shift_carry)
  );

  // Operation select and per-operation carry/overflow.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    Alu_result = '0;
    Carry      = 1'b0;
    Overflow   = 1'b0;
    sum        = {1'b0, Alu_inputA} + {1'b0, Alu_inputB};
    diff       = {1'b0, Alu_inputA} - {1'b0, Alu_inputB};
    case (op)
      ALU_ADD: begin
        Alu_result = sum[DATA_W-1:0];
        Carry      = sum[DATA_W];
        Overflow   = (sign_a == sign_b) && (sum[DATA_W-1] != sign_a);
      end
      ALU_SUB: begin
        Alu_result = diff[DATA_W-1:0];
        Carry      = diff[DATA_W];  // borrow: A < B unsigned
        Overflow   = (sign_a != sign_b) && (diff[DATA_W-1] != sign_a);
      end
      ALU_AND: Alu_result = Alu_inputA & Alu_inputB;
      ALU_OR:  Alu_result = Alu_inputA | Alu_inputB;
      ALU_XOR: Alu_result = Alu_inputA ^ Alu_inputB;
      ALU_SLT: Alu_result = {{(DATA_W-1){1'b0}},
                             ($signed(Alu_inputA) < $signed(Alu_inputB))};
      ALU_SLL, ALU_SRL: begin
        Alu_result = shift_result;
        Carry      = shift_carry;
      end
    endcase
  end

  // Zero is taken from the final result for every operation.
  assign Zero = (Alu_result == '0);

  // Registered copies of result and flags, loaded every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Alu_result_q <= '0;
      Zero_q       <= 1'b0;
      Carry_q      <= 1'b0;
      Overflow_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers sample the same
      // pre-edge values regardless of statement order.
      Alu_result_q <= Alu_result;
      Zero_q       <= Zero;
      Carry_q      <= Carry;
      Overflow_q   <= Overflow;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the ALU.
module tb_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic [2:0]  ctrl;
  logic [15:0] res;
  logic        zero;
  logic        carry;
  logic        ovf;
  logic [15:0] res_q;
  logic        zero_q;
  logic        carry_q;
  logic        ovf_q;

  int checks = 0;
  int errors = 0;

  alu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Alu_inputA   (a),
    .Alu_inputB   (b),
    .Alu_control  (ctrl),
    .Alu_result   (res),
    .Zero         (zero),
    .Carry        (carry),
    .Overflow     (ovf),
    .Alu_result_q (res_q),
    .Zero_q       (zero_q),
    .Carry_q      (carry_q),
    .Overflow_q   (ovf_q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [18:0] observed,
                       input logic [18:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive a vector, let it settle, compare {result, zero, carry, overflow}.
  task automatic vec(input string tag, input logic [15:0] va,
                     input logic [15:0] vb, input logic [2:0] op,
                     input logic [15:0] e_res, input logic e_z,
                     input logic e_c, input logic e_v);
    a = va;
    b = vb;
    ctrl = op;
    #1;
    check(tag, {res, zero, carry, ovf}, {e_res, e_z, e_c, e_v});
  endtask

  initial begin
    rst_n = 1'b0;
    a = '0;
    b = '0;
    ctrl = 3'd0;
    #2;
    check("reset_q", {res_q, zero_q, carry_q, ovf_q}, 19'h0);

    // Combinational vectors while still in reset: outputs must not care.
    vec("add",  16'hAB03, 16'h32FF, 3'd0, 16'hDE02, 1'b0, 1'b0, 1'b0);
    vec("sub",  16'hAB03, 16'h32FF, 3'd1, 16'h7804, 1'b0, 1'b0, 1'b1);
    vec("and",  16'hAB03, 16'h32FF, 3'd2, 16'h2203, 1'b0, 1'b0, 1'b0);
    vec("or",   16'hAB03, 16'h32FF, 3'd3, 16'hBBFF, 1'b0, 1'b0, 1'b0);
    vec("xor",  16'hAB03, 16'h32FF, 3'd4, 16'h99FC, 1'b0, 1'b0, 1'b0);
    vec("slt",  16'hAB03, 16'h32FF, 3'd5, 16'h0001, 1'b0, 1'b0, 1'b0);
    vec("slt0", 16'h32FF, 16'hAB03, 3'd5, 16'h0000, 1'b1, 1'b0, 1'b0);
    vec("sll4", 16'hAB03, 16'h0004, 3'd6, 16'hB030, 1'b0, 1'b0, 1'b0);
    vec("srl4", 16'hAB03, 16'h0004, 3'd7, 16'h0AB0, 1'b0, 1'b0, 1'b0);
    vec("add_wrap", 16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0);
    vec("add_ovf",  16'h7FFF, 16'h0001, 3'd0, 16'h8000, 1'b0, 1'b0, 1'b1);
    vec("sub_eq",   16'h1234, 16'h1234, 3'd1, 16'h0000, 1'b1, 1'b0, 1'b0);
    vec("sub_borrow", 16'h0001, 16'h0002, 3'd1, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    vec("sll0",  16'h8001, 16'h0000, 3'd6, 16'h8001, 1'b0, 1'b0, 1'b0);
    vec("sll_hi", 16'h8001, 16'hFFF1, 3'd6, 16'h0002, 1'b0, 1'b1, 1'b0);
    vec("srl_hi", 16'h8001, 16'hFFF1, 3'd7, 16'h4000, 1'b0, 1'b1, 1'b0);
    vec("srl15", 16'hC000, 16'h000F, 3'd7, 16'h0001, 1'b0, 1'b1, 1'b0);
    vec("srl0",  16'h8001, 16'h0010, 3'd7, 16'h8001, 1'b0, 1'b0, 1'b0);
    check("reset_hold_q", {res_q, zero_q, carry_q, ovf_q}, 19'h0);

    // Release reset away from the edge, then check one-cycle latency.
    @(negedge clk);
    rst_n = 1'b1;
    vec("v1", 16'h7FFF, 16'h0001, 3'd0, 16'h8000, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("q_v1", {res_q, zero_q, carry_q, ovf_q}, {16'h8000, 1'b0, 1'b0, 1'b1});
    vec("v2", 16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0);
    check("q_hold_v1", {res_q, zero_q, carry_q, ovf_q}, {16'h8000, 1'b0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    check("q_v2", {res_q, zero_q, carry_q, ovf_q}, {16'h0000, 1'b1, 1'b1, 1'b0});
    vec("v3", 16'hAB03, 16'h32FF, 3'd1, 16'h7804, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("q_v3", {res_q, zero_q, carry_q, ovf_q}, {16'h7804, 1'b0, 1'b0, 1'b1});

    // Mid-run reset: registers clear at once, combinational path untouched.
    #2;
    rst_n = 1'b0;
    #1;
    check("q_async_clr", {res_q, zero_q, carry_q, ovf_q}, 19'h0);
    check("comb_in_reset", {res, zero, carry, ovf}, {16'h7804, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    rst_n = 1'b1;
    check("q_before_edge", {res_q, zero_q, carry_q, ovf_q}, 19'h0);
    @(posedge clk);
    #1;
    check("q_after_release", {res_q, zero_q, carry_q, ovf_q}, {16'h7804, 1'b0, 1'b0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for the registered copies of result and flags.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 Alu_inputA  input  16  operand A.
REQ-005 Alu_inputB  input  16  operand B; only bits [3:0] are used as the shift amount for the shift operations.
REQ-006 Alu_control  input  3  operation select.
REQ-007 Alu_result  output  16  combinational result.
REQ-008 Zero  output  1  combinational flag; 1 when Alu_result equals 16'h0000.
REQ-009 Carry  output  1  combinational carry/borrow/shift-out flag.
REQ-010 Overflow  output  1  combinational signed-overflow flag.
REQ-011 Alu_result_q, Zero_q, Carry_q, Overflow_q  outputs  16/1/1/1  registered copies of Alu_result, Zero, Carry and Overflow.

Function
REQ-012 Alu_result, Zero, Carry and Overflow SHALL be purely combinational with zero-cycle latency, settling within the same time step as any input change, and SHALL be independent of clk and rst_n.
REQ-013 Alu_control encoding:
- 0 ADD: A+B, mod 2^16.
- 1 SUB: A-B, mod 2^16.
- 2 AND: A&B.
- 3 OR: A|B.
- 4 XOR: A^B.
- 5 SLT: 16'h0001 if A<B as signed two's-complement, else 16'h0000.
- 6 SLL: A<<B[3:0], zero-filled.
- 7 SRL: A>>B[3:0], logical, zero-filled.
REQ-014 Carry SHALL be defined per operation:
- ADD: carry out of bit 15.
- SUB: borrow, i.e. 1 when A<B unsigned.
- SLL: the last bit shifted out, A[16-B[3:0]].
- SRL: the last bit shifted out, A[B[3:0]-1].
- Shift by 0: Carry=0.
- All other operations: Carry=0.
REQ-015 Overflow SHALL be defined per operation:
- ADD: 1 when the operands have equal signs and the result sign differs from them.
- SUB: 1 when the operands have differing signs and the result sign differs from A.
- All other operations: Overflow=0.
REQ-016 Zero SHALL be evaluated on the final Alu_result for every operation, including SLT and the shifts.
REQ-017 On each rising clk edge while rst_n=1, the _q outputs SHALL load the current combinational values, giving one-cycle latency and updating every cycle with no enable.
REQ-018 Operand bits B[15:4] SHALL have no effect on SLL or SRL.

Reset
REQ-019 While rst_n=0, Alu_result_q SHALL be 16'h0000 and Zero_q, Carry_q and Overflow_q SHALL be 0, immediately and without waiting for clk.
REQ-020 Asserting reset mid-operation SHALL NOT affect the combinational outputs.
REQ-021 After rst_n deasserts, the first rising clk edge SHALL capture the live values.

Structure
REQ-022 A shared package alu_pkg SHALL hold:
- the 3-bit opcode constants ALU_ADD..ALU_SRL (values 0..7);
- the data-width constant, 16.
REQ-023 One sub-module, alu_shifter, SHALL implement the SLL/SRL barrel shifter and its shift-out carry.
REQ-024 All other logic (arithmetic, logic operations, flags, output registers) SHALL reside in alu.

Verification
REQ-025 A=16'hAB03, B=16'h32FF, control 0..4 SHALL produce:
- ADD: DE02, Carry=0, Overflow=0.
- SUB: 7804, Carry=0, Overflow=1.
- AND: 2203.
- OR: BBFF.
- XOR: 99FC.
- Zero=0 in all five cases.
REQ-026 A=16'hAB03, B=16'h32FF, control 5 (SLT) SHALL produce 0001, since A is negative and B is positive.
REQ-027 A=16'hAB03, B=16'h0004 SHALL produce:
- control 6 (SLL): B030, Carry=0.
- control 7 (SRL): 0AB0, Carry=0.
REQ-028 Zero/overflow boundary cases SHALL produce:
- A=16'hFFFF, B=16'h0001, ADD: 0000, Zero=1, Carry=1.
- A=16'h7FFF, B=16'h0001, ADD: 8000, Overflow=1.
- A=B=16'h1234, SUB: 0000, Zero=1, Carry=0.
REQ-029 A shift by 0 and a shift amount with upper bits set SHALL behave as follows:
- A=16'h8001, B=16'h0000, SLL: 8001, Carry=0.
- A=16'h8001, B=16'hFFF1, SLL: 0002, Carry=1 (shift amount 1; B[15:4] ignored).
REQ-030 Registered outputs SHALL behave as follows:
- rst_n=0 mid-run: all _q outputs clear asynchronously.
- After release: the _q outputs equal the previous cycle's combinational values on each rising edge.
